hls_macc_vec_obf: RTL and testbench
===================================

Name: hls_macc_vec_obf

Overview:
- Parametrised successor to the fixed four-state HLS multiply-accumulate block.
- Computes a signed N-lane dot product plus gain and bias, and counts lanes whose product exceeds a threshold.
- One multiplier is time-shared across lanes under an ap_start/ap_done/ap_idle/ap_ready handshake.
- Threshold and bias constants are key-locked: stored encoded, XOR-decoded by locking_key; a wrong key gives wrong but well-formed results.

Parameters:
- W, 32, datapath width in bits (signed two's complement).
- N, 4, lane count, N >= 1.
- CW, $clog2(N+1), width of the lane counter and of o2.
- THR_ENC, 32'hA6A92B5F, encoded threshold (W bits).
- BIAS_ENC, 32'h00000000, encoded bias (W bits).
- KEY_W, 2*W, locking key width.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse in DONE.
- ap_idle  out  1  high in IDLE while ap_start is low.
- ap_ready  out  1  one-cycle pulse in DONE.
- i_a  in  N*W  packed lane operands A; lane k is bits [k*W +: W].
- i_b  in  N*W  packed lane operands B.
- g1  in  W  gain added to the sum.
- o1  out  W  result: sum + g1 + BIAS.
- o1_ap_vld  out  1  one-cycle valid for o1.
- o2  out  CW  count of lanes with product > THR.
- o2_ap_vld  out  1  one-cycle valid for o2.
- locking_key  in  KEY_W  unlock key.

Behaviour:
- Key decode (combinational):
  - THR = THR_ENC ^ locking_key[W-1:0]
  - BIAS = BIAS_ENC ^ locking_key[2W-1:W]
  - The key is not latched; it must be stable during operation.
- States: IDLE, MAC, FIN, DONE, one-hot, 4 bits.
- Reset (async, any state): state=IDLE; acc, idx, cnt, latched operands, o1 and o2 all cleared to 0; all valid/done/ready low. Reset mid-operation abandons the computation with no output pulse.
- IDLE:
  - ap_start=1: latch i_a, i_b, g1; acc=0, cnt=0, idx=0; go to MAC.
  - Otherwise stay in IDLE.
- MAC, one lane per cycle:
  - prod = signed(a[idx]) * signed(b[idx]), truncated to W bits.
  - acc += prod, modulo 2^W.
  - If signed(prod) > signed(THR), cnt += 1.
  - If idx == N-1, go to FIN; else idx += 1.
- FIN: o1 <= acc + g1 + BIAS (modulo 2^W); o2 <= cnt; go to DONE.
- DONE: ap_done, ap_ready, o1_ap_vld, o2_ap_vld all high for exactly this cycle; go to IDLE.
- Latency: start accepted at cycle 0; DONE at cycle N+2 (without PIPE_MUL_EN).
- o1 and o2 hold their values until the next FIN.
- Inputs may change after the start cycle without effect.
- ap_start held high continuously: the next run begins on the cycle after DONE returns to IDLE. Throughput is one result per N+3 cycles.
- N=1: MAC lasts exactly one cycle.
- Overflow wraps silently; there is no saturation.
- Comparison is strictly greater-than, signed.

Optional Feature:
- Macro: HLS_MACC_PIPE_MUL_EN.
- Defined:
  - A register stage sits between multiplier and accumulator.
  - MAC lasts N+1 cycles: the first cycle only fills the stage; the last cycle only drains it.
  - Latency becomes N+3.
  - The product register resets to 0.
- Undefined: combinational multiply-accumulate, latency N+2.
- Results are identical in both builds.

Decomposition:
- Package hls_macc_pkg holds:
  - the state encoding (ST_IDLE=4'd1, ST_MAC=4'd2, ST_FIN=4'd4, ST_DONE=4'd8);
  - the default THR_ENC/BIAS_ENC constants;
  - the key_decode function (enc, key slice) -> value.
- One sub-module, hls_macc_lane_mul: signed W x W multiply with truncation and the optional register stage. It owns the HLS_MACC_PIPE_MUL_EN logic.

Test Plan:
- Unlocked basic run. Key set so THR=10, BIAS=5 (key[31:0]=THR_ENC^10, key[63:32]=5); W=32, N=4; A={1,2,3,4}, B={5,6,7,8}, g1=3; one-cycle ap_start.
  - Required: o1=78, o2=3.
  - Valids, ap_done and ap_ready pulse together at cycle 6 (cycle 7 with PIPE).
  - ap_idle low from cycle 1 through DONE.
- Wrong key: same stimulus with locking_key=0, so THR=0xA6A92B5F (negative) and BIAS=0.
  - Required: o1=73, o2=4.
- Negative and overflow: A={-3,0x7FFFFFFF,0,0}, B={4,2,0,0}, g1=0, THR=10, BIAS=5.
  - Required: o1 = -12 + 0xFFFFFFFE + 5 mod 2^32 = 0xFFFFFFF7; o2=0.
- Back-to-back: ap_start held high for 3 runs.
  - Required: exactly 3 done pulses spaced N+3=7 cycles apart; o1 correct for each run's latched inputs.
  - Inputs are changed mid-run and must have no effect.
- Reset mid-MAC: assert ap_rst_n=0 at cycle 3.
  - Required: immediately (asynchronously) state=IDLE, o1=0, o2=0, no valid pulse.
  - A subsequent run gives correct results.
- N=1 build: A={-2}, B={-6}, g1=1, THR=10, BIAS=5.
  - Required: o1=18, o2=1, DONE at cycle 3.

Source files
------------

// File: rtl/hls_macc_pkg.sv
// ---------------------------------------------------------------------------
// hls_macc_pkg
//   Shared definitions for the key-locked multiply-accumulate block:
//   - one-hot FSM state encoding (IDLE/MAC/FIN/DONE)
//   - default encoded threshold and bias constants
//   - key_decode(): XOR-unlock of an encoded constant
//   key_decode works on a fixed KEY_DEC_W-bit container. Callers size their
//   operands into it and cast the result back, so datapaths up to
//   KEY_DEC_W bits wide are supported.
// ---------------------------------------------------------------------------
package hls_macc_pkg;

  localparam logic [3:0] ST_IDLE = 4'd1;
  localparam logic [3:0] ST_MAC  = 4'd2;
  localparam logic [3:0] ST_FIN  = 4'd4;
  localparam logic [3:0] ST_DONE = 4'd8;

  localparam logic [31:0] THR_ENC_DEFAULT  = 32'hA6A92B5F;
  localparam logic [31:0] BIAS_ENC_DEFAULT = 32'h00000000;

  localparam int KEY_DEC_W = 64;

  // A wrong key still yields a legal value; it is simply the wrong constant.
  function automatic logic [KEY_DEC_W-1:0] key_decode(
    input logic [KEY_DEC_W-1:0] enc,
    input logic [KEY_DEC_W-1:0] key_slice
  );
    return enc ^ key_slice;
  endfunction

endpackage

// File: rtl/hls_macc_lane_mul.sv
// ---------------------------------------------------------------------------
// hls_macc_lane_mul
//   Signed W x W multiply truncated to W bits, with an optional register
//   stage selected by the HLS_MACC_PIPE_MUL_EN macro.
//   Ports:
//     clk, rst_n   clock / async active-low reset (pipelined build only)
//     in_vld       a lane operand pair is presented this cycle
//     in_last      the presented lane is the final lane
//     a, b         lane operands (two's complement)
//     out_vld      prod is valid this cycle
//     out_last     prod belongs to the final lane
//     prod         low W bits of a*b
//   Macro HLS_MACC_PIPE_MUL_EN: when defined, prod/out_vld/out_last are
//   registered (one cycle later); otherwise they are combinational.
// ---------------------------------------------------------------------------
module hls_macc_lane_mul #(
  parameter int W = 32
) (
`ifdef HLS_MACC_PIPE_MUL_EN
  input  logic         clk,
  input  logic         rst_n,
`endif
  input  logic         in_vld,
  input  logic         in_last,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_vld,
  output logic         out_last,
  output logic [W-1:0] prod
);

  // The low W bits of a product are the same for signed and unsigned
  // operands, so a W-bit context gives the truncated signed product directly.
  logic [W-1:0] mul;
  assign mul = $signed(a) * $signed(b);

`ifdef HLS_MACC_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      out_vld  <= in_vld;
      out_last <= in_vld && in_last;
      if (in_vld) prod <= mul;
    end
  end
`else
  assign prod     = mul;
  assign out_vld  = in_vld;
  assign out_last = in_last;
`endif

endmodule

// File: rtl/hls_macc_vec_obf.sv
// ---------------------------------------------------------------------------
// hls_macc_vec_obf
//   Key-locked N-lane signed dot product with gain and bias, plus a count of
//   lanes whose product exceeds a threshold. One time-shared multiplier
//   processes one lane per cycle under an ap_* handshake.
//   Ports:
//     ap_clk, ap_rst_n   clock / async active-low reset
//     ap_start           run request, sampled only in IDLE
//     ap_done, ap_ready  one-cycle pulse in DONE
//     ap_idle            IDLE and no pending request
//     i_a, i_b           packed lane operands, lane k at [k*W +: W]
//     g1                 gain added to the sum
//     o1, o1_ap_vld      sum + g1 + BIAS, valid pulse in DONE
//     o2, o2_ap_vld      lanes with product > THR, valid pulse in DONE
//     locking_key        [W-1:0] unlocks THR, [2W-1:W] unlocks BIAS
//   Macro HLS_MACC_PIPE_MUL_EN: registers the multiplier output; MAC takes
//   N+1 cycles and latency grows by one. Results are unchanged.
// ---------------------------------------------------------------------------
module hls_macc_vec_obf
  import hls_macc_pkg::*;
#(
  parameter int             W        = 32,
  parameter int             N        = 4,
  parameter int             CW       = $clog2(N+1),
  parameter logic [W-1:0]   THR_ENC  = W'(THR_ENC_DEFAULT),
  parameter logic [W-1:0]   BIAS_ENC = W'(BIAS_ENC_DEFAULT),
  parameter int             KEY_W    = 2*W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [N*W-1:0]   i_a,
  input  logic [N*W-1:0]   i_b,
  input  logic [W-1:0]     g1,
  output logic [W-1:0]     o1,
  output logic             o1_ap_vld,
  output logic [CW-1:0]    o2,
  output logic             o2_ap_vld,
  input  logic [KEY_W-1:0] locking_key
);

  logic [3:0]     state;
  logic [N*W-1:0] a_lat;
  logic [N*W-1:0] b_lat;
  logic [W-1:0]   g1_lat;
  logic [W-1:0]   acc;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  cnt;

  // The key is deliberately not registered: it must be held stable by the
  // system for as long as the block is in use.
  logic [W-1:0] thr;
  logic [W-1:0] bias;
  assign thr  = W'(key_decode(KEY_DEC_W'(THR_ENC),  KEY_DEC_W'(locking_key[W-1:0])));
  assign bias = W'(key_decode(KEY_DEC_W'(BIAS_ENC), KEY_DEC_W'(locking_key[2*W-1:W])));

  // idx counts lanes issued to the multiplier. It reaches N only in the
  // pipelined build's drain cycle, where nothing is issued.
  logic          issue;
  logic          issue_last;
  logic [CW-1:0] lane;
  logic [W-1:0]  a_lane;
  logic [W-1:0]  b_lane;
  logic          prod_vld;
  logic          prod_last;
  logic [W-1:0]  prod;

  assign issue      = (state == ST_MAC) && (idx != CW'(N));
  assign issue_last = (idx == CW'(N-1));
  assign lane       = issue ? idx : '0;  // keep the part-select in range
  assign a_lane     = a_lat[lane*W +: W];
  assign b_lane     = b_lat[lane*W +: W];

  hls_macc_lane_mul #(.W(W)) u_mul (
`ifdef HLS_MACC_PIPE_MUL_EN
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
`endif
    .in_vld   (issue),
    .in_last  (issue_last),
    .a        (a_lane),
    .b        (b_lane),
    .out_vld  (prod_vld),
    .out_last (prod_last),
    .prod     (prod)
  );

  // NOTE: every register below uses <= so all of them sample the values
  // from before the edge; blocking = here would create order-dependent races.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= ST_IDLE;
      a_lat  <= '0;
      b_lat  <= '0;
      g1_lat <= '0;
      acc    <= '0;
      idx    <= '0;
      cnt    <= '0;
      o1     <= '0;
      o2     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            a_lat  <= i_a;
            b_lat  <= i_b;
            g1_lat <= g1;
            acc    <= '0;
            cnt    <= '0;
            idx    <= '0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (issue) idx <= idx + CW'(1);
          if (prod_vld) begin
            acc <= acc + prod;
            if ($signed(prod) > $signed(thr)) cnt <= cnt + CW'(1);
            if (prod_last) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          o1    <= acc + g1_lat + bias;
          o2    <= cnt;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ap_done   = (state == ST_DONE);
  assign ap_ready  = (state == ST_DONE);
  assign o1_ap_vld = (state == ST_DONE);
  assign o2_ap_vld = (state == ST_DONE);
  assign ap_idle   = (state == ST_IDLE) && !ap_start;

endmodule

// File: tb/tb_hls_macc_vec_obf.sv
// ---------------------------------------------------------------------------
// tb_hls_macc_vec_obf
//   Self-checking bench for hls_macc_vec_obf: an N=4 instance for the main
//   scenarios and an N=1 instance for the single-lane case. Expected results
//   come from a plain-arithmetic dot-product model.
// ---------------------------------------------------------------------------
module tb_hls_macc_vec_obf;

  localparam int W      = 32;
  localparam int N      = 4;
  localparam int CW     = $clog2(N+1);
  localparam int PERIOD = 10;
  localparam logic [31:0] THR_ENC  = 32'hA6A92B5F;
  localparam logic [31:0] BIAS_ENC = 32'h00000000;
  localparam logic [63:0] KEY_OK   = {32'd5, THR_ENC ^ 32'd10};  // THR=10, BIAS=5
`ifdef HLS_MACC_PIPE_MUL_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic           ap_clk;
  logic           ap_rst_n;
  logic           ap_start;
  logic           ap_done, ap_idle, ap_ready;
  logic [N*W-1:0] i_a, i_b;
  logic [W-1:0]   g1;
  logic [W-1:0]   o1;
  logic           o1_ap_vld, o2_ap_vld;
  logic [CW-1:0]  o2;
  logic [2*W-1:0] locking_key;

  logic           s1_start, s1_done, s1_idle, s1_ready;
  logic [W-1:0]   s1_a, s1_b, s1_g1, s1_o1;
  logic           s1_o1_vld, s1_o2_vld;
  logic [0:0]     s1_o2;

  int n_err = 0;
  int n_chk = 0;
  int n_done = 0;

  hls_macc_vec_obf #(.W(W), .N(N)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .i_a(i_a), .i_b(i_b), .g1(g1),
    .o1(o1), .o1_ap_vld(o1_ap_vld), .o2(o2), .o2_ap_vld(o2_ap_vld),
    .locking_key(locking_key)
  );

  hls_macc_vec_obf #(.W(W), .N(1)) dut_n1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(s1_start),
    .ap_done(s1_done), .ap_idle(s1_idle), .ap_ready(s1_ready),
    .i_a(s1_a), .i_b(s1_b), .g1(s1_g1),
    .o1(s1_o1), .o1_ap_vld(s1_o1_vld), .o2(s1_o2), .o2_ap_vld(s1_o2_vld),
    .locking_key(locking_key)
  );

  initial ap_clk = 1'b0;
  always #(PERIOD/2) ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (ap_done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed dot product of n lanes, each product wrapped to 32 bits.
  function automatic void model(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                input int n, input logic [31:0] g, input logic [63:0] k,
                                output logic [31:0] r1, output int r2);
    int thr, bias, sum, p;
    thr  = int'(THR_ENC ^ k[31:0]);
    bias = int'(BIAS_ENC ^ k[63:32]);
    sum  = 0;
    r2   = 0;
    for (int i = 0; i < n; i++) begin
      p = int'(longint'($signed(a[i*32 +: 32])) * longint'($signed(b[i*32 +: 32])));
      sum += p;
      if (p > thr) r2++;
    end
    r1 = sum + int'(g) + bias;
  endfunction

  function automatic logic [31:0] rand_lane();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 40)) - 32'd20;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = rand_lane();
    return v;
  endfunction

  // One complete run on the N=4 instance with handshake, latency and hold checks.
  task automatic run_check(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                           input logic [31:0] g, input logic [63:0] k,
                           input logic [31:0] exp_o1, input int exp_o2);
    int cyc;
    int idle_bad;
    @(negedge ap_clk);
    i_a = a; i_b = b; g1 = g; locking_key = k; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    cyc = 1;
    idle_bad = 0;
    while (ap_done !== 1'b1 && cyc < 40) begin
      if (ap_idle !== 1'b0) idle_bad++;
      @(posedge ap_clk); #1;
      cyc++;
    end
    if (ap_idle !== 1'b0) idle_bad++;
    check({tag, "_latency"}, 64'(cyc), 64'(N + 2 + EXTRA));
    check({tag, "_idle_low"}, 64'(idle_bad), 64'd0);
    check({tag, "_pulses"}, {60'd0, ap_done, ap_ready, o1_ap_vld, o2_ap_vld}, 64'hF);
    check({tag, "_o1"}, 64'(o1), 64'(exp_o1));
    check({tag, "_o2"}, 64'(o2), 64'(exp_o2));
    @(posedge ap_clk); #1;
    check({tag, "_pulse_end"}, {60'd0, ap_done, ap_ready, o1_ap_vld, o2_ap_vld}, 64'h0);
    check({tag, "_o1_hold"}, 64'(o1), 64'(exp_o1));
  endtask

  initial begin
    logic [N*W-1:0] va, vb;
    logic [31:0]    vg, e1;
    logic [63:0]    vk;
    int             e2, cyc, done_before;
    longint         t_done[3];

    ap_rst_n = 1'b0; ap_start = 1'b0; i_a = '0; i_b = '0; g1 = '0; locking_key = '0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_g1 = '0;
    repeat (3) @(negedge ap_clk);
    check("reset_o1", 64'(o1), 64'd0);
    check("reset_o2", 64'(o2), 64'd0);
    check("reset_idle", {62'd0, ap_idle, ap_done}, 64'h2);
    ap_rst_n = 1'b1;

    // Unlocked basic run, then the same operands with the all-zero key.
    va = {32'd4, 32'd3, 32'd2, 32'd1};
    vb = {32'd8, 32'd7, 32'd6, 32'd5};
    run_check("basic", va, vb, 32'd3, KEY_OK, 32'd78, 3);
    run_check("wrong_key", va, vb, 32'd3, 64'd0, 32'd73, 4);

    // Negative operands and product overflow.
    run_check("neg_ovf", {32'd0, 32'd0, 32'h7FFFFFFF, -32'sd3}, {32'd0, 32'd0, 32'd2, 32'd4},
              32'd0, KEY_OK, 32'hFFFFFFF7, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      va = rand_vec(); vb = rand_vec(); vg = $urandom;
      vk = {32'($urandom), THR_ENC ^ (32'($urandom_range(0, 200)) - 32'd100)};
      model(va, vb, N, vg, vk, e1, e2);
      run_check($sformatf("rand%0d", r), va, vb, vg, vk, e1, e2);
    end

    // Back-to-back: start held high for three runs, inputs scrambled mid-run.
    done_before = n_done;
    locking_key = KEY_OK;
    @(negedge ap_clk);
    i_a = rand_vec(); i_b = rand_vec(); g1 = $urandom; ap_start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      model(i_a, i_b, N, g1, locking_key, e1, e2);
      if (r != 0) @(posedge ap_clk);  // DONE -> IDLE edge
      @(posedge ap_clk); #1;          // start latched on this edge
      @(posedge ap_clk); #1;
      i_a = rand_vec(); i_b = rand_vec(); g1 = $urandom;
      cyc = 0;
      while (ap_done !== 1'b1 && cyc < 40) begin
        @(posedge ap_clk); #1;
        cyc++;
      end
      t_done[r] = longint'($time);
      check($sformatf("b2b%0d_done", r), {63'd0, ap_done}, 64'd1);
      check($sformatf("b2b%0d_o1", r), 64'(o1), 64'(e1));
      check($sformatf("b2b%0d_o2", r), 64'(o2), 64'(e2));
      if (r == 2) ap_start = 1'b0;
      else begin
        i_a = rand_vec(); i_b = rand_vec(); g1 = $urandom;
      end
    end
    repeat (12) @(posedge ap_clk);
    #1;
    check("b2b_gap01", 64'(t_done[1] - t_done[0]), 64'((N + 3 + EXTRA) * PERIOD));
    check("b2b_gap12", 64'(t_done[2] - t_done[1]), 64'((N + 3 + EXTRA) * PERIOD));
    check("b2b_count", 64'(n_done - done_before), 64'd3);

    // Reset asserted in the middle of MAC.
    @(negedge ap_clk);
    i_a = {32'd4, 32'd3, 32'd2, 32'd1}; i_b = {32'd8, 32'd7, 32'd6, 32'd5}; g1 = 32'd3;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #3;
    done_before = n_done;
    ap_rst_n = 1'b0;
    #1;
    check("rst_mid_idle", {63'd0, ap_idle}, 64'd1);
    check("rst_mid_o1", 64'(o1), 64'd0);
    check("rst_mid_o2", 64'(o2), 64'd0);
    check("rst_mid_pulses", {60'd0, ap_done, ap_ready, o1_ap_vld, o2_ap_vld}, 64'h0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (8) @(negedge ap_clk);
    check("rst_mid_no_done", 64'(n_done - done_before), 64'd0);
    run_check("after_rst", {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5},
              32'd3, KEY_OK, 32'd78, 3);

    // Single-lane instance.
    @(negedge ap_clk);
    s1_a = -32'sd2; s1_b = -32'sd6; s1_g1 = 32'd1; locking_key = KEY_OK; s1_start = 1'b1;
    @(posedge ap_clk); #1;
    s1_start = 1'b0;
    cyc = 1;
    while (s1_done !== 1'b1 && cyc < 40) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    check("n1_latency", 64'(cyc), 64'(3 + EXTRA));
    check("n1_o1", 64'(s1_o1), 64'd18);
    check("n1_o2", 64'(s1_o2), 64'd1);
    check("n1_pulses", {60'd0, s1_done, s1_ready, s1_o1_vld, s1_o2_vld}, 64'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
